record_serializer: RTL and testbench

- Downstream neighbour of the sequence parser.
- Accepts parsed 296-bit payload records plus their packet-lost flag over a val/ready handshake, and buffers them in a DEPTH-entry record FIFO.
- Serializes each record as ten 32-bit words on a val/ready/last stream for the 32-bit egress path.
- Keeps a saturating count of records that arrived flagged as lost.

---
 rtl/record_pkg.sv | 30 +++
 rtl/rec_fifo.sv | 46 ++++
 rtl/record_serializer.sv | 95 +++++++++
 tb/tb_record_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/record_pkg.sv
// Shared constants, types and the word-select helper for the record serializer slice.
// Used by rec_fifo and record_serializer.
package record_pkg;

   localparam int REC_W          = 296;
   localparam int WORD_W         = 32;
   localparam int WORDS_PER_REC  = 10;
   localparam int LAST_WORD_BITS = 8;

   typedef logic [3:0] word_idx_t;

   typedef struct packed {
      logic [0:REC_W-1] payload;
      logic             lost;
   } rec_entry_t;

   // Byte 0 of the payload lands in dataOut[31:24]; the tail word carries the final byte only.
   function automatic logic [WORD_W-1:0] rec_word(input logic [0:REC_W-1] payload,
                                                  input word_idx_t        idx);
      logic [WORD_W-1:0] w;
      w = '0;
      for (int i = 0; i < WORDS_PER_REC - 1; i++) begin
         if (idx == word_idx_t'(i)) w = payload[i*WORD_W +: WORD_W];
      end
      if (idx == word_idx_t'(WORDS_PER_REC - 1))
         w = {payload[REC_W-LAST_WORD_BITS +: LAST_WORD_BITS], {(WORD_W-LAST_WORD_BITS){1'b0}}};
      return w;
   endfunction

endpackage

// File: rtl/rec_fifo.sv
// Record FIFO: DEPTH entries of {payload, lost}, pointers with an extra wrap bit.
// The caller must not push while full or pop while empty.
module rec_fifo
   import record_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  rec_entry_t             wr_data,
   input  logic                   pop,
   output rec_entry_t             rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   rec_entry_t  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; contents are only observed through a valid pointer range.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/record_serializer.sv
// Buffers 296-bit records and streams each as ten 32-bit words; counts lost-flagged records.
// RECORD_SERIALIZER_DROP_ON_FULL_EN: always ready, records offered while full are dropped and counted.
module record_serializer
   import record_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [0:REC_W-1]       recIn,
   input  logic                   recIn_lost,
   input  logic                   recIn_val,
   output logic                   recIn_ready,
   output logic [WORD_W-1:0]      dataOut,
   output logic                   dataOut_val,
   input  logic                   dataOut_ready,
   output logic                   dataOut_last,
   output logic                   dataOut_lost,
   output logic [CNT_W-1:0]       lostCount,
`ifdef RECORD_SERIALIZER_DROP_ON_FULL_EN
   output logic [CNT_W-1:0]       dropCount,
`endif
   output logic [$clog2(DEPTH):0] fifoLevel
);

   localparam word_idx_t        LAST_IDX = word_idx_t'(WORDS_PER_REC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   rec_entry_t       wr_entry;
   rec_entry_t       head;
   logic             full;
   logic             empty;
   logic             accept;
   logic             push;
   logic             pop;
   logic             word_acc;
   word_idx_t        idx;
   logic [CNT_W-1:0] lost_cnt;

`ifdef RECORD_SERIALIZER_DROP_ON_FULL_EN
   logic             drop;
   logic [CNT_W-1:0] drop_cnt;

   assign recIn_ready = 1'b1;
   assign drop        = recIn_val & full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                       drop_cnt <= '0;
      else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
   end

   assign dropCount = drop_cnt;
`else
   // No bypass: a pop in the same cycle does not open the door for a push.
   assign recIn_ready = !full;
`endif

   assign accept   = recIn_val & recIn_ready;
   assign push     = accept & !full;
   assign wr_entry = {recIn, recIn_lost};

   assign dataOut_val = !empty;
   assign word_acc    = dataOut_val & dataOut_ready;
   assign pop         = word_acc & (idx == LAST_IDX);

   rec_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data (wr_entry),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (fifoLevel)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          idx <= '0;
      else if (word_acc)  idx <= (idx == LAST_IDX) ? '0 : idx + word_idx_t'(1);
   end

   // Dropped records still count here when flagged, since accept covers them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                      lost_cnt <= '0;
      else if (accept && recIn_lost && lost_cnt != '1) lost_cnt <= lost_cnt + CNT_ONE;
   end

   assign lostCount    = lost_cnt;
   assign dataOut      = rec_word(head.payload, idx);
   assign dataOut_last = dataOut_val & (idx == LAST_IDX);
   assign dataOut_lost = dataOut_val & head.lost;

endmodule

// File: tb/tb_record_serializer.sv
// Self-checking bench for record_serializer: directed scenarios plus randomized traffic
// checked against a queue-based record model.
module tb_record_serializer;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;
   localparam int SAT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [0:295]     recIn = '0;
   logic             recIn_lost = 1'b0;
   logic             recIn_val = 1'b0;
   logic             recIn_ready;
   logic [31:0]      dataOut;
   logic             dataOut_val;
   logic             dataOut_ready = 1'b0;
   logic             dataOut_last;
   logic             dataOut_lost;
   logic [CNT_W-1:0] lostCount;
   logic [2:0]       fifoLevel;

   logic             sat_val = 1'b0;
   logic             sat_ready;
   logic [31:0]      sat_data;
   logic             sat_dval;
   logic             sat_last;
   logic             sat_lost_o;
   logic [SAT_W-1:0] sat_lost_cnt;
   logic [2:0]       sat_level;
   logic [0:295]     sat_rec = '0;

`ifdef RECORD_SERIALIZER_DROP_ON_FULL_EN
   logic [CNT_W-1:0] dropCount;
   logic [SAT_W-1:0] sat_drop_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Model: queue of {lost, payload}; payload byte k sits at bits [295-8k -: 8].
   logic [296:0] q[$];
   int m_idx = 0;
   int m_lost = 0;
   int m_drop = 0;

   always #5 clk = ~clk;

   record_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .recIn         (recIn),
      .recIn_lost    (recIn_lost),
      .recIn_val     (recIn_val),
      .recIn_ready   (recIn_ready),
      .dataOut       (dataOut),
      .dataOut_val   (dataOut_val),
      .dataOut_ready (dataOut_ready),
      .dataOut_last  (dataOut_last),
      .dataOut_lost  (dataOut_lost),
      .lostCount     (lostCount),
`ifdef RECORD_SERIALIZER_DROP_ON_FULL_EN
      .dropCount     (dropCount),
`endif
      .fifoLevel     (fifoLevel)
   );

   record_serializer #(.DEPTH(DEPTH), .CNT_W(SAT_W)) dut_sat (
      .clk           (clk),
      .reset         (reset),
      .recIn         (sat_rec),
      .recIn_lost    (1'b1),
      .recIn_val     (sat_val),
      .recIn_ready   (sat_ready),
      .dataOut       (sat_data),
      .dataOut_val   (sat_dval),
      .dataOut_ready (1'b1),
      .dataOut_last  (sat_last),
      .dataOut_lost  (sat_lost_o),
      .lostCount     (sat_lost_cnt),
`ifdef RECORD_SERIALIZER_DROP_ON_FULL_EN
      .dropCount     (sat_drop_cnt),
`endif
      .fifoLevel     (sat_level)
   );

   function automatic logic [31:0] exp_word(input logic [296:0] r, input int j);
      if (j == 9) return {r[7:0], 24'h0};
      return r[295-32*j -: 32];
   endfunction

   function automatic bit m_ready();
`ifdef RECORD_SERIALIZER_DROP_ON_FULL_EN
      return 1'b1;
`else
      return q.size() < DEPTH;
`endif
   endfunction

   function automatic logic [295:0] rand_rec();
      logic [319:0] t;
      for (int i = 0; i < 10; i++) t[32*i +: 32] = $urandom;
      return t[295:0];
   endfunction

   // Drive one cycle of inputs, let the edge happen, advance the model, settle 1 time unit.
   task automatic cycle(input logic val, input logic lost, input logic [295:0] rec, input logic rdy);
      bit old_full, acc, wacc;
      logic [296:0] dummy;
      recIn_val = val; recIn_lost = lost; recIn = rec; dataOut_ready = rdy;
      old_full = q.size() >= DEPTH;
      acc  = val && m_ready();
      wacc = (q.size() > 0) && rdy;
      @(posedge clk);
      if (wacc) begin
         if (m_idx == 9) begin m_idx = 0; dummy = q.pop_front(); end
         else m_idx++;
      end
      if (acc && !old_full) q.push_back({lost, rec});
      if (acc && old_full && m_drop < 65535) m_drop++;
      if (acc && lost && m_lost < 65535) m_lost++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; recIn_val = 1'b0; dataOut_ready = 1'b0; sat_val = 1'b0;
      #2;
      q.delete(); m_idx = 0; m_lost = 0; m_drop = 0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3 reset = 1'b1;
      #1;
      vectors++; if (dataOut_val !== 1'b0) begin miscompares++; $display("FAIL reset_val got %b exp 0", dataOut_val); end
      vectors++; if (dataOut_last !== 1'b0) begin miscompares++; $display("FAIL reset_last got %b exp 0", dataOut_last); end
      vectors++; if (dataOut_lost !== 1'b0) begin miscompares++; $display("FAIL reset_lost got %b exp 0", dataOut_lost); end
      vectors++; if (fifoLevel !== 3'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", fifoLevel); end
      vectors++; if (lostCount !== 16'd0) begin miscompares++; $display("FAIL reset_lostcount got %0d exp 0", lostCount); end
`ifdef RECORD_SERIALIZER_DROP_ON_FULL_EN
      vectors++; if (dropCount !== 16'd0) begin miscompares++; $display("FAIL reset_dropcount got %0d exp 0", dropCount); end
`endif
      do_reset();
      vectors++; if (recIn_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", recIn_ready); end
   endtask

   task automatic test_single_record();
      logic [295:0] r;
      for (int k = 0; k < 37; k++) r[295-8*k -: 8] = 8'(k);
      do_reset();
      cycle(1'b1, 1'b0, r, 1'b1);
      for (int j = 0; j < 10; j++) begin
         vectors++; if (dataOut_val !== 1'b1) begin miscompares++; $display("FAIL single_val w%0d got %b exp 1", j, dataOut_val); end
         vectors++; if (dataOut !== exp_word(q[0], m_idx)) begin miscompares++; $display("FAIL single_word w%0d got %h exp %h", j, dataOut, exp_word(q[0], m_idx)); end
         vectors++; if (dataOut_last !== (j == 9)) begin miscompares++; $display("FAIL single_last w%0d got %b exp %b", j, dataOut_last, j == 9); end
         if (j == 0) begin vectors++; if (dataOut !== 32'h00010203) begin miscompares++; $display("FAIL single_w0 got %h exp 00010203", dataOut); end end
         if (j == 8) begin vectors++; if (dataOut !== 32'h20212223) begin miscompares++; $display("FAIL single_w8 got %h exp 20212223", dataOut); end end
         if (j == 9) begin vectors++; if (dataOut !== 32'h24000000) begin miscompares++; $display("FAIL single_w9 got %h exp 24000000", dataOut); end end
         cycle(1'b0, 1'b0, '0, 1'b1);
      end
      vectors++; if (dataOut_val !== 1'b0) begin miscompares++; $display("FAIL single_done_val got %b exp 0", dataOut_val); end
   endtask

   task automatic test_backpressure();
      logic [31:0] prev;
      bit hold, rdy;
      int accepts;
      do_reset();
      cycle(1'b1, 1'b0, rand_rec(), 1'b0);
      hold = 0; prev = '0; accepts = 0;
      for (int i = 0; i < 20; i++) begin
         rdy = (i % 2 == 0);
         vectors++; if (fifoLevel !== 3'(q.size())) begin miscompares++; $display("FAIL bp_level c%0d got %0d exp %0d", i, fifoLevel, q.size()); end
         if (q.size() > 0) begin
            vectors++; if (dataOut !== exp_word(q[0], m_idx)) begin miscompares++; $display("FAIL bp_word c%0d got %h exp %h", i, dataOut, exp_word(q[0], m_idx)); end
         end
         if (hold) begin
            vectors++; if (dataOut !== prev) begin miscompares++; $display("FAIL bp_hold c%0d got %h exp %h", i, dataOut, prev); end
         end
         hold = dataOut_val && !rdy;
         prev = dataOut;
         if (dataOut_val && rdy) accepts++;
         cycle(1'b0, 1'b0, '0, rdy);
      end
      vectors++; if (accepts !== 10) begin miscompares++; $display("FAIL bp_accepts got %0d exp 10", accepts); end
      vectors++; if (fifoLevel !== 3'd0) begin miscompares++; $display("FAIL bp_final_level got %0d exp 0", fifoLevel); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), rand_rec(), 1'b0);
      vectors++; if (fifoLevel !== 3'd4) begin miscompares++; $display("FAIL fill_level got %0d exp 4", fifoLevel); end
`ifdef RECORD_SERIALIZER_DROP_ON_FULL_EN
      vectors++; if (recIn_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready got %b exp 1", recIn_ready); end
      vectors++; if (dropCount !== 16'd1) begin miscompares++; $display("FAIL fill_dropcount got %0d exp 1", dropCount); end
`else
      vectors++; if (recIn_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b exp 0", recIn_ready); end
`endif
      vectors++; if (lostCount !== 16'(m_lost)) begin miscompares++; $display("FAIL fill_lostcount got %0d exp %0d", lostCount, m_lost); end
      for (int j = 0; j < 40; j++) begin
         vectors++; if (dataOut_val !== 1'b1) begin miscompares++; $display("FAIL fill_val w%0d got %b exp 1", j, dataOut_val); end
         if (q.size() > 0) begin
            vectors++; if (dataOut !== exp_word(q[0], m_idx)) begin miscompares++; $display("FAIL fill_word w%0d got %h exp %h", j, dataOut, exp_word(q[0], m_idx)); end
            vectors++; if (dataOut_last !== (m_idx == 9)) begin miscompares++; $display("FAIL fill_last w%0d got %b exp %b", j, dataOut_last, m_idx == 9); end
         end
         cycle(1'b0, 1'b0, '0, 1'b1);
      end
      vectors++; if (fifoLevel !== 3'd0) begin miscompares++; $display("FAIL fill_drained got %0d exp 0", fifoLevel); end
   endtask

   task automatic test_lost_flag();
      bit exp_l;
      do_reset();
      cycle(1'b1, 1'b1, rand_rec(), 1'b0);
      cycle(1'b1, 1'b0, rand_rec(), 1'b0);
      cycle(1'b1, 1'b1, rand_rec(), 1'b0);
      vectors++; if (lostCount !== 16'd2) begin miscompares++; $display("FAIL lost_count got %0d exp 2", lostCount); end
      for (int j = 0; j < 30; j++) begin
         exp_l = (j / 10) != 1;
         vectors++; if (dataOut_lost !== exp_l) begin miscompares++; $display("FAIL lost_flag w%0d got %b exp %b", j, dataOut_lost, exp_l); end
         cycle(1'b0, 1'b0, '0, 1'b1);
      end
      vectors++; if (lostCount !== 16'd2) begin miscompares++; $display("FAIL lost_count_after got %0d exp 2", lostCount); end
   endtask

   task automatic test_lost_saturate();
      do_reset();
      sat_val = 1'b1;
      for (int i = 0; i < 3; i++) @(posedge clk);
      #1;
      vectors++; if (sat_lost_cnt !== 4'd3) begin miscompares++; $display("FAIL sat_partial got %0d exp 3", sat_lost_cnt); end
      for (int i = 0; i < 250; i++) @(posedge clk);
      #1;
      vectors++; if (sat_lost_cnt !== 4'hF) begin miscompares++; $display("FAIL sat_reach got %0d exp 15", sat_lost_cnt); end
      for (int i = 0; i < 100; i++) @(posedge clk);
      #1;
      vectors++; if (sat_lost_cnt !== 4'hF) begin miscompares++; $display("FAIL sat_hold got %0d exp 15", sat_lost_cnt); end
      sat_val = 1'b0;
   endtask

   task automatic test_full_pop();
      logic [295:0] nr;
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, rand_rec(), 1'b0);
      nr = rand_rec();
      for (int j = 0; j < 10; j++) begin
         vectors++; if (fifoLevel !== 3'd4) begin miscompares++; $display("FAIL fp_level w%0d got %0d exp 4", j, fifoLevel); end
         vectors++; if (recIn_ready !== m_ready()) begin miscompares++; $display("FAIL fp_ready w%0d got %b exp %b", j, recIn_ready, m_ready()); end
         if (j == 9) begin
            vectors++; if (dataOut_last !== 1'b1) begin miscompares++; $display("FAIL fp_last got %b exp 1", dataOut_last); end
         end
         cycle(1'b1, 1'b0, nr, 1'b1);
      end
      vectors++; if (fifoLevel !== 3'd3) begin miscompares++; $display("FAIL fp_level_after_pop got %0d exp 3", fifoLevel); end
      vectors++; if (recIn_ready !== 1'b1) begin miscompares++; $display("FAIL fp_ready_after_pop got %b exp 1", recIn_ready); end
      cycle(1'b1, 1'b0, nr, 1'b0);
      vectors++; if (fifoLevel !== 3'd4) begin miscompares++; $display("FAIL fp_level_refill got %0d exp 4", fifoLevel); end
   endtask

   task automatic test_reset_mid();
      logic [295:0] nr;
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, rand_rec(), 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1);
      vectors++; if (fifoLevel !== 3'd3) begin miscompares++; $display("FAIL mid_level_pre got %0d exp 3", fifoLevel); end
      vectors++; if (dataOut !== exp_word(q[0], 5)) begin miscompares++; $display("FAIL mid_word5 got %h exp %h", dataOut, exp_word(q[0], 5)); end
      dataOut_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      vectors++; if (dataOut_val !== 1'b0) begin miscompares++; $display("FAIL mid_val got %b exp 0", dataOut_val); end
      vectors++; if (fifoLevel !== 3'd0) begin miscompares++; $display("FAIL mid_level got %0d exp 0", fifoLevel); end
      vectors++; if (lostCount !== 16'd0) begin miscompares++; $display("FAIL mid_lostcount got %0d exp 0", lostCount); end
      q.delete(); m_idx = 0; m_lost = 0; m_drop = 0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      nr = rand_rec();
      cycle(1'b1, 1'b0, nr, 1'b1);
      for (int j = 0; j < 10; j++) begin
         vectors++; if (dataOut !== exp_word({1'b0, nr}, j)) begin miscompares++; $display("FAIL mid_restart w%0d got %h exp %h", j, dataOut, exp_word({1'b0, nr}, j)); end
         cycle(1'b0, 1'b0, '0, 1'b1);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         vectors++; if (recIn_ready !== m_ready()) begin miscompares++; $display("FAIL rnd_ready c%0d got %b exp %b", i, recIn_ready, m_ready()); end
         vectors++; if (dataOut_val !== (q.size() > 0)) begin miscompares++; $display("FAIL rnd_val c%0d got %b exp %b", i, dataOut_val, q.size() > 0); end
         vectors++; if (fifoLevel !== 3'(q.size())) begin miscompares++; $display("FAIL rnd_level c%0d got %0d exp %0d", i, fifoLevel, q.size()); end
         vectors++; if (lostCount !== 16'(m_lost)) begin miscompares++; $display("FAIL rnd_lostcount c%0d got %0d exp %0d", i, lostCount, m_lost); end
`ifdef RECORD_SERIALIZER_DROP_ON_FULL_EN
         vectors++; if (dropCount !== 16'(m_drop)) begin miscompares++; $display("FAIL rnd_dropcount c%0d got %0d exp %0d", i, dropCount, m_drop); end
`endif
         if (q.size() > 0) begin
            vectors++; if (dataOut !== exp_word(q[0], m_idx)) begin miscompares++; $display("FAIL rnd_word c%0d got %h exp %h", i, dataOut, exp_word(q[0], m_idx)); end
            vectors++; if (dataOut_last !== (m_idx == 9)) begin miscompares++; $display("FAIL rnd_last c%0d got %b exp %b", i, dataOut_last, m_idx == 9); end
            vectors++; if (dataOut_lost !== q[0][296]) begin miscompares++; $display("FAIL rnd_lost c%0d got %b exp %b", i, dataOut_lost, q[0][296]); end
         end
         cycle(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), rand_rec(),
               1'($urandom_range(0, 3) != 0));
      end
   endtask

   initial begin
      test_reset();
      test_single_record();
      test_backpressure();
      test_fill();
      test_lost_flag();
      test_lost_saturate();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
